// File: rtl/mult_div_if.sv
// Issue/result bundle between the execute stage and the iterative multiply/divide unit.
// The master side issues operations and MTHI/MTLO writes; the slave side returns HI/LO and mult_done.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             mult_done;

  modport master (
    output start, op, srca, srcb, hi_we, lo_we, wd,
    input  hi, lo, mult_done
  );

  modport slave (
    input  start, op, srca, srcb, hi_we, lo_we, wd,
    output hi, lo, mult_done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// It produces one result bit per cycle on magnitudes, then applies sign correction in a final FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  mult_div_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             r_state;
  logic [1:0]         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_orig_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // op[0]=0 selects the signed variants; op[1]=1 selects divide.
  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  assign w_signed = ~bus.op[0];
  assign w_neg_a  = w_signed & bus.srca[WIDTH-1];
  assign w_neg_b  = w_signed & bus.srcb[WIDTH-1];
  assign w_abs_a  = w_neg_a ? (~bus.srca + 1'b1) : bus.srca;
  assign w_abs_b  = w_neg_b ? (~bus.srcb + 1'b1) : bus.srcb;

  // Multiply step: conditionally add the multiplicand into the upper half, then shift right.
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring divide step: the quotient register shifts the dividend out of its MSB while
  // quotient bits enter at its LSB. A negative trial (MSB set) restores the shifted remainder.
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quot_next;

  assign w_shifted   = {r_rem, r_acc[WIDTH-1]};
  assign w_trial     = w_shifted - {1'b0, r_b};
  assign w_rem_next  = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quot_next = {r_acc[WIDTH-2:0], ~w_trial[WIDTH]};

  logic               w_neg_res;
  logic               w_div_zero;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_neg_res  = r_sign_a ^ r_sign_b;
  assign w_div_zero = (r_b == '0);
  assign w_prod_fix = w_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_quot_fix = w_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sign_a ? (~r_rem + 1'b1) : r_rem;

  // NOTE: every state register uses non-blocking assignment so all updates in this block
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_orig_a <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.hi_we) r_hi <= bus.wd;
          if (bus.lo_we) r_lo <= bus.wd;
          if (bus.start) begin
            r_op     <= bus.op;
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_orig_a <= bus.srca;
            r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
            r_rem    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          if (r_op[1]) begin
            r_rem <= w_rem_next;
            r_acc <= {{WIDTH{1'b0}}, w_quot_next};
          end else begin
            r_acc <= w_mul_next;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
        end

        S_FIX: begin
          if (!r_op[1]) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else if (w_div_zero) begin
            r_hi <= r_orig_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.mult_done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned multiply and divide results,
// divide-by-zero, async reset abort, ignored re-issue and MTHI/MTLO gating.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  mult_div_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one operation so that start is sampled on the next rising edge, then drops start.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts negedges with mult_done low; pulses start (with junk operands) at cycle inject_at.
  task automatic wait_done(input int inject_at, output int cycles);
    cycles = 0;
    while (!bus.mult_done && cycles < 200) begin
      cycles++;
      if (cycles == inject_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.srca  = 32'h0000_0002;
        bus.srcb  = 32'h0000_0003;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  int cycles;
  int extra_drops;

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.srca    = '0;
    bus.srcb    = '0;
    bus.hi_we   = 1'b0;
    bus.lo_we   = 1'b0;
    bus.wd      = '0;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("reset_hi",   bus.hi, 32'h0);
    check("reset_lo",   bus.lo, 32'h0);
    check("reset_done", {31'b0, bus.mult_done}, 32'h1);

    // MULTU max * max, with exact busy latency
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(-1, cycles);
    check("multu_max_cycles", cycles, 33);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);

    // Async reset mid-RUN aborts without touching HI/LO afterwards
    issue(2'b01, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_hi",   bus.hi, 32'h0);
    check("abort_lo",   bus.lo, 32'h0);
    check("abort_done", {31'b0, bus.mult_done}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    extra_drops = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.mult_done) extra_drops++;
    end
    check("post_abort_hi",    bus.hi, 32'h0);
    check("post_abort_lo",    bus.lo, 32'h0);
    check("post_abort_drops", extra_drops, 0);

    // MULT -3 * 7, operand changed right after acceptance
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    bus.srca = 32'h0000_0100;
    bus.srcb = 32'h0000_0100;
    bus.op   = 2'b11;
    wait_done(-1, cycles);
    check("mult_neg_cycles", cycles, 33);
    check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);

    issue(2'b00, 32'h0000_0005, 32'hFFFF_FFFC);
    wait_done(-1, cycles);
    check("mult_5xm4_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_5xm4_lo", bus.lo, 32'hFFFF_FFEC);

    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(-1, cycles);
    check("mult_min_sq_hi", bus.hi, 32'h4000_0000);
    check("mult_min_sq_lo", bus.lo, 32'h0000_0000);

    // Divides
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(-1, cycles);
    check("div_m7_2_cycles", cycles, 33);
    check("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);

    issue(2'b10, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done(-1, cycles);
    check("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_7_m2_hi", bus.hi, 32'h0000_0001);

    issue(2'b11, 32'd100, 32'd7);
    wait_done(-1, cycles);
    check("divu_100_7_lo", bus.lo, 32'd14);
    check("divu_100_7_hi", bus.hi, 32'd2);

    issue(2'b11, 32'hFFFF_FFFF, 32'h0001_0000);
    wait_done(-1, cycles);
    check("divu_big_lo", bus.lo, 32'h0000_FFFF);
    check("divu_big_hi", bus.hi, 32'h0000_FFFF);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(-1, cycles);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0000_0000);

    // Divide by zero, with a second start pulsed mid-RUN that must be ignored
    issue(2'b11, 32'h1234_5678, 32'h0000_0000);
    wait_done(5, cycles);
    check("divu_zero_cycles", cycles, 33);
    check("divu_zero_hi", bus.hi, 32'h1234_5678);
    check("divu_zero_lo", bus.lo, 32'hFFFF_FFFF);
    extra_drops = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.mult_done) extra_drops++;
    end
    check("ignored_start_drops", extra_drops, 0);
    check("ignored_start_hi", bus.hi, 32'h1234_5678);

    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
    wait_done(-1, cycles);
    check("div_zero_hi", bus.hi, 32'hFFFF_FFF9);
    check("div_zero_lo", bus.lo, 32'hFFFF_FFFF);

    // MTHI in IDLE lands on the next edge
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wd    = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_hi", bus.hi, 32'hA5A5_A5A5);
    check("mthi_lo", bus.lo, 32'hFFFF_FFFF);

    // MTLO during RUN is dropped; HI/LO hold until FIX
    issue(2'b01, 32'd5, 32'd6);
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wd    = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo_run_lo", bus.lo, 32'hFFFF_FFFF);
    check("mtlo_run_hi", bus.hi, 32'hA5A5_A5A5);
    wait_done(-1, cycles);
    check("mtlo_run_cycles", cycles, 31);
    check("multu_5x6_hi", bus.hi, 32'h0);
    check("multu_5x6_lo", bus.lo, 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
